// File: rtl/load_value_table.sv
// load_value_table: direct-mapped, stride-based load value predictor.
// A lookup returns last_value + stride for the load PC, one cycle later.
// A resolved load trains the entry: a repeated stride builds confidence,
// and a new stride resets it. A new PC or a tag conflict reallocates the entry.
module load_value_table #(
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_WIDTH  = 2,
  parameter int CONF_THRESH = 2,
  localparam int ADDR_WIDTH = 32,
  localparam int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_value,
  output logic                  pred_hit,
  output logic                  pred_confident,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [DATA_WIDTH-1:0] update_value
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int ENTRIES   = 1 << INDEX_WIDTH;

  // Table storage. Only the valid bits are reset. The other fields are
  // meaningful only behind a set valid bit.
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] last_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] stride_q [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_q   [ENTRIES];

  // Update side
  logic [INDEX_WIDTH-1:0] upd_idx;
  logic [TAG_WIDTH-1:0]   upd_tag;
  logic                   upd_en;
  logic                   upd_hit;
  logic [DATA_WIDTH-1:0]  new_stride;
  logic [DATA_WIDTH-1:0]  nxt_stride;
  logic [CONF_WIDTH-1:0]  nxt_conf;

  // Lookup side (entry as it will look after this cycle's update)
  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   e_valid;
  logic [TAG_WIDTH-1:0]   e_tag;
  logic [DATA_WIDTH-1:0]  e_last;
  logic [DATA_WIDTH-1:0]  e_stride;
  logic [CONF_WIDTH-1:0]  e_conf;
  logic                   lk_hit;

  assign upd_idx = update_pc[INDEX_WIDTH+1:2];
  assign upd_tag = update_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign lk_idx  = lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag  = lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Flush and reset both drop any update presented in the same cycle.
  assign upd_en  = update_valid && !flush && !rst;

  // Next contents of the entry selected by the update: train on a hit, reallocate on a miss.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt_stride = '0;
    nxt_conf   = '0;
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    new_stride = update_value - last_q[upd_idx];
    if (upd_hit) begin
      if (new_stride == stride_q[upd_idx]) begin
        nxt_stride = stride_q[upd_idx];
        nxt_conf   = (conf_q[upd_idx] == '1) ? conf_q[upd_idx]
                                             : conf_q[upd_idx] + 1'b1;
      end else begin
        nxt_stride = new_stride;
      end
    end
  end

  // Select the lookup entry. Forward the pending update when both use the same index.
  always_comb begin
    e_valid  = valid_q[lk_idx];
    e_tag    = tag_q[lk_idx];
    e_last   = last_q[lk_idx];
    e_stride = stride_q[lk_idx];
    e_conf   = conf_q[lk_idx];
    if (upd_en && (lk_idx == upd_idx)) begin
      e_valid  = 1'b1;
      e_tag    = upd_tag;
      e_last   = update_value;
      e_stride = nxt_stride;
      e_conf   = nxt_conf;
    end
    lk_hit = e_valid && (e_tag == lk_tag) && !flush;
  end

  // Valid bits: cleared together on reset or flush, set by an accepted update.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (rst || flush) begin
      valid_q <= '0;
    end else if (upd_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload writes.
  always_ff @(posedge clk) begin
    // NOTE: the payload arrays are deliberately not reset. Clearing valid_q is enough, and the arrays can stay plain RAM.
    if (upd_en) begin
      tag_q[upd_idx]    <= upd_tag;
      last_q[upd_idx]   <= update_value;
      stride_q[upd_idx] <= nxt_stride;
      conf_q[upd_idx]   <= nxt_conf;
    end
  end

  // Registered prediction result. pred_value holds while no result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid     <= 1'b0;
      pred_value     <= '0;
      pred_hit       <= 1'b0;
      pred_confident <= 1'b0;
    end else begin
      pred_valid     <= lookup_valid;
      pred_hit       <= 1'b0;
      pred_confident <= 1'b0;
      if (lookup_valid) begin
        if (lk_hit) begin
          pred_value     <= e_last + e_stride;
          pred_hit       <= 1'b1;
          pred_confident <= (32'(e_conf) >= CONF_THRESH);
        end else begin
          pred_value     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_value_table.sv
// Self-checking bench for load_value_table. A behavioural table model applies
// each cycle's flush or update first and then answers the lookup. This ordering
// gives the bypass behaviour directly.
module tb_load_value_table;

  localparam int IW      = 6;
  localparam int CONF_MX = 3;
  localparam int THRESH  = 2;
  localparam int N       = 1 << IW;

  logic        clk = 1'b0;
  logic        rst, flush, lookup_valid, update_valid;
  logic [31:0] lookup_pc, update_pc, update_value;
  logic        pred_valid, pred_hit, pred_confident;
  logic [31:0] pred_value;

  load_value_table #(.INDEX_WIDTH(IW), .CONF_WIDTH(2), .CONF_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_value(pred_value),
    .pred_hit(pred_hit), .pred_confident(pred_confident),
    .update_valid(update_valid), .update_pc(update_pc), .update_value(update_value)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_last   [N];
  logic [31:0] m_stride [N];
  int          m_conf   [N];

  // Expected outputs after the most recent drive()
  bit          e_pv, e_hit, e_conf;
  logic [31:0] e_value = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IW + 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] val);
    int i;
    logic [31:0] s;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      s = val - m_last[i];
      if (s == m_stride[i]) m_conf[i] = (m_conf[i] < CONF_MX) ? m_conf[i] + 1 : CONF_MX;
      else begin m_stride[i] = s; m_conf[i] = 0; end
      m_last[i] = val;
    end else begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc);
      m_last[i] = val; m_stride[i] = 0; m_conf[i] = 0;
    end
  endtask

  // Apply one cycle of stimulus to the DUT and model, then wait until just after the clock edge.
  task automatic drive(input bit r, input bit f, input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] uval);
    int i;
    rst = r; flush = f; lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_value = uval;
    if (r) begin
      model_clear();
      e_pv = 0; e_hit = 0; e_conf = 0; e_value = 0;
    end else begin
      if (f) model_clear();
      else if (uv) model_update(upc, uval);
      e_pv = lv; e_hit = 0; e_conf = 0;
      if (lv) begin
        i = idx_of(lpc);
        if (!f && m_valid[i] && m_tag[i] == tag_of(lpc)) begin
          e_hit = 1; e_value = m_last[i] + m_stride[i]; e_conf = (m_conf[i] >= THRESH);
        end else e_value = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
    drive(0, 0, 1, 32'h400, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_lookup_miss: got v=%0b h=%0b c=%0b val=%0d, expected v=1 h=0 c=0 val=0",
               pred_valid, pred_hit, pred_confident, pred_value);
    end
  endtask

  task automatic test_stride_train();
    drive(0, 0, 0, 0, 1, 32'h400, 100);
    drive(0, 0, 0, 0, 1, 32'h400, 104);
    drive(0, 0, 0, 0, 1, 32'h400, 108);
    drive(0, 0, 1, 32'h400, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL train_unconfident: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
    drive(0, 0, 0, 0, 1, 32'h400, 112);
    drive(0, 0, 1, 32'h400, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL train_confident: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
  endtask

  task automatic test_stride_break();
    drive(0, 0, 0, 0, 1, 32'h400, 200);
    drive(0, 0, 1, 32'h400, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL stride_break: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
  endtask

  task automatic test_tag_conflict();
    drive(0, 0, 0, 0, 1, 32'h400 + (4 << IW), 7);
    drive(0, 0, 1, 32'h400, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL tag_conflict_old: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
    drive(0, 0, 1, 32'h400 + (4 << IW), 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL tag_conflict_new: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
  endtask

  task automatic test_bypass();
    drive(0, 0, 1, 32'h404, 1, 32'h404, 50);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b1, 1'b1, 1'b0, 32'd50}) begin
      n_fail++;
      $display("FAIL bypass_alloc: got v=%0b h=%0b c=%0b val=%0d, expected v=1 h=1 c=0 val=50",
               pred_valid, pred_hit, pred_confident, pred_value);
    end
    // The next update sets the stride and must also be visible in the same cycle.
    drive(0, 0, 1, 32'h404, 1, 32'h404, 53);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL bypass_train: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 0, 0, 1, 32'h500, 10);
    drive(0, 0, 0, 0, 1, 32'h500, 20);
    drive(0, 1, 1, 32'h500, 1, 32'h500, 30);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_same_cycle: got v=%0b h=%0b c=%0b val=%0d, expected v=1 h=0 c=0 val=0",
               pred_valid, pred_hit, pred_confident, pred_value);
    end
    drive(0, 0, 1, 32'h500, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_update_dropped: got v=%0b h=%0b c=%0b val=%0d, expected v=1 h=0 c=0 val=0",
               pred_valid, pred_hit, pred_confident, pred_value);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 32'h600, 1000);
    drive(0, 0, 0, 0, 1, 32'h600, 1010);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, (k % 2) ? 32'h600 : 32'h404, 0, 0, 0);
      n_tests++;
      if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
                 k, pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
      end
    end
    idle();
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b0, 1'b0, 1'b0, e_value}) begin
      n_fail++;
      $display("FAIL value_hold: got v=%0b h=%0b c=%0b val=%0d, expected v=0 h=0 c=0 val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_value);
    end
  endtask

  task automatic test_reset_midstream();
    drive(0, 0, 0, 0, 1, 32'h700, 5);
    drive(1, 0, 1, 32'h700, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_midstream: got v=%0b h=%0b c=%0b val=%0d, expected v=0 h=0 c=0 val=0",
               pred_valid, pred_hit, pred_confident, pred_value);
    end
    drive(0, 0, 1, 32'h700, 0, 0, 0);
    n_tests++;
    if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
      n_fail++;
      $display("FAIL reset_clears_table: got v=%0b h=%0b c=%0b val=%0d, expected v=%0b h=%0b c=%0b val=%0d",
               pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
    end
  endtask

  // Random traffic over a few indices and aliasing tags, with mostly regular strides.
  task automatic test_random();
    logic [31:0] pcs [8];
    logic [31:0] base [8];
    logic [31:0] step [8];
    int a, b;
    bit lv, uv, fl;
    for (int i = 0; i < 8; i++) begin
      pcs[i]  = 32'h1000 + ((i % 4) << 2) + ((i / 4) << (IW + 2));
      base[i] = $urandom;
      step[i] = $urandom_range(1, 16);
    end
    for (int k = 0; k < 400; k++) begin
      a  = $urandom_range(0, 7);
      b  = $urandom_range(0, 7);
      lv = ($urandom_range(0, 3) != 0);
      uv = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 49) == 0);
      if (uv) begin
        base[b] = base[b] + (($urandom_range(0, 7) == 0) ? $urandom : step[b]);
      end
      drive(0, fl, lv, pcs[a], uv, pcs[b], base[b]);
      n_tests++;
      if ({pred_valid, pred_hit, pred_confident, pred_value} !== {e_pv, e_hit, e_conf, e_value}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b h=%0b c=%0b val=%0h, expected v=%0b h=%0b c=%0b val=%0h",
                 k, pred_valid, pred_hit, pred_confident, pred_value, e_pv, e_hit, e_conf, e_value);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stride_train();
    test_stride_break();
    test_tag_conflict();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
